md_sched: RTL and testbench
===========================

Name: md_sched

Overview:
- Sequencer and hazard controller for the multiply/divide resource and the HI/LO register pair in the E stage of the five-stage pipeline.
- Accepts one HI/LO operation per cycle from the E stage and models the multi-cycle latency of mult/div.
- Commits results to HI/LO on completion.
- Generates the stall that holds D-stage HI/LO users, and gates new operations when the pipeline flushes for an interrupt or exception.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be ≥1).
- DIV_CYCLES, 10, busy cycles for div/divu (must be ≥1).
- CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- op_E  in  3  E-stage operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7 is treated as none.
- rs_E  in  32  forwarded rs value (dividend / multiplicand / mthi/mtlo source).
- rt_E  in  32  forwarded rt value (divisor / multiplier).
- flush  in  1  IntReq or ExcReq; the E-stage instruction is being squashed this cycle.
- md_D  in  1  D-stage instruction reads or writes HI/LO (mult/div/mfhi/mflo/mthi/mtlo).
- start  out  1  combinational; a mult/div is accepted this cycle.
- busy  out  1  registered; a mult/div is in flight.
- stall_md  out  1  combinational, equal to md_D && (start || busy).
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, busy=0, counter=0, hi=0, lo=0, pending result=0.
- Acceptance:
  - An operation is accepted only when state is IDLE, flush=0 and op_E≠none.
  - start=1 for mult/multu/div/divu under these conditions.
- States are IDLE and RUN.
- IDLE → RUN on start:
  - counter loads MULT_CYCLES or DIV_CYCLES.
  - The full 64-bit result is computed from rs_E/rt_E in that cycle and latched into {phi, plo}.
  - mult/multu produce the signed/unsigned 64-bit product: phi = upper 32 bits, plo = lower 32 bits.
  - div produces signed quotient → plo and remainder → phi, truncating toward zero; the remainder takes the sign of the dividend.
  - divu produces unsigned quotient and remainder.
  - Divide by zero: result is discarded; hi/lo stay unchanged at completion, but the busy timing still applies.
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- RUN:
  - busy=1; the counter decrements each cycle.
  - When counter==1 on a rising edge: hi←phi, lo←plo, busy←0, state←IDLE.
  - busy is therefore high for exactly N cycles after the start cycle.
  - The result is visible on hi/lo in the first cycle with busy=0.
- mthi/mtlo:
  - Accepted in IDLE when flush=0; hi or lo is written with rs_E on the next edge.
  - Single cycle; no start, no busy.
- Operations arriving while busy:
  - Any op_E≠none while busy is ignored: no state change, hi/lo untouched.
  - Upstream stall_md guarantees this never occurs in correct operation.
- flush:
  - flush=1 blocks acceptance in the same cycle: start=0, no mthi/mtlo write.
  - flush has no effect on an operation already in RUN. The operation is older than the faulting instruction and has committed, so it completes normally.
- Back-to-back operations: a new op is accepted in the first IDLE cycle following completion.
- Reset asserted mid-RUN: the operation is aborted immediately and all state returns to reset values.
- stall_md is asserted during the start cycle as well as while busy, so a dependent mfhi in D is held until the result is committed.

Decomposition:
- Shared package (define header) holds:
  - op encodings MD_NONE..MD_MTLO.
  - state encodings S_IDLE/S_RUN.
  - default latencies.
- One natural sub-module, md_arith: purely combinational 64-bit mult/div result generator (op, rs, rt → phi, plo, div0). The md_sched top keeps the FSM, counter and HI/LO registers.

Test Plan:
- Reset, then mult rs=0xFFFFFFFE rt=3 → start=1 for one cycle; busy=1 for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- divu rs=100 rt=7 with md_D=1 held → stall_md=1 for the start cycle plus 10 busy cycles; then lo=14, hi=2, stall_md=0.
- div rs=-7 rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then div rs=5 rt=0 → busy 10 cycles, hi/lo unchanged.
- mult with flush=1 in the same cycle → start=0, busy stays 0, hi/lo unchanged. flush pulsed during an active RUN → completes, result committed.
- mthi rs=0x1234 → hi=0x1234 next cycle, busy=0. A mtlo issued while busy → ignored; lo retains the mult result.
- reset driven low at busy cycle 3 of a div → busy=0, hi=lo=0 immediately (asynchronous); a new multu after release behaves normally.

Source files
------------

// File: rtl/md_sched_pkg.sv
// Shared encodings and default latencies for the HI/LO multiply/divide sequencer.
package md_sched_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7   // decodes as no operation
  } md_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } md_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W_DEF       = 4;

  // True for the multi-cycle ops that occupy the mult/div resource.
  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_sched_if.sv
// E/D-stage facing signals of the HI/LO sequencer.
interface md_sched_if;
  logic [2:0]  op_E;
  logic [31:0] rs_E;
  logic [31:0] rt_E;
  logic        flush;
  logic        md_D;
  logic        start;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;

  // Pipeline side: issues ops, observes HI/LO and the stall.
  modport master (
    output op_E, rs_E, rt_E, flush, md_D,
    input  start, busy, stall_md, hi, lo
  );

  // Sequencer side.
  modport slave (
    input  op_E, rs_E, rt_E, flush, md_D,
    output start, busy, stall_md, hi, lo
  );
endinterface

// File: rtl/md_arith.sv
// Combinational 64-bit mult/div result generator; {phi, plo} = {HI, LO} candidate.
module md_arith
  import md_sched_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rt,
  output logic [31:0] o_phi,
  output logic [31:0] o_plo,
  output logic        o_div0
);

  logic [63:0] w_sprod, w_uprod;
  logic [31:0] w_ars, w_art, w_sdiv, w_udiv;
  logic [31:0] w_mq, w_mr, w_uq, w_ur, w_sq, w_sr;

  assign w_sprod = $signed({{32{i_rs[31]}}, i_rs}) * $signed({{32{i_rt[31]}}, i_rt});
  assign w_uprod = {32'd0, i_rs} * {32'd0, i_rt};

  // Signed divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 rem 0
  // instead of hitting the signed-overflow corner of the / operator.
  assign w_ars  = i_rs[31] ? (32'd0 - i_rs) : i_rs;
  assign w_art  = i_rt[31] ? (32'd0 - i_rt) : i_rt;
  // Divisor of zero is replaced by one only to keep the datapath X-free;
  // the result is discarded via o_div0.
  assign w_sdiv = (i_rt == 32'd0) ? 32'd1 : w_art;
  assign w_udiv = (i_rt == 32'd0) ? 32'd1 : i_rt;

  assign w_mq = w_ars / w_sdiv;
  assign w_mr = w_ars % w_sdiv;
  assign w_uq = i_rs / w_udiv;
  assign w_ur = i_rs % w_udiv;
  // Quotient truncates toward zero; remainder follows the dividend sign.
  assign w_sq = (i_rs[31] ^ i_rt[31]) ? (32'd0 - w_mq) : w_mq;
  assign w_sr = i_rs[31] ? (32'd0 - w_mr) : w_mr;

  // Select result by operation.
  always_comb begin
    o_phi  = 32'd0;
    o_plo  = 32'd0;
    o_div0 = 1'b0;
    case (i_op)
      MD_MULT:  {o_phi, o_plo} = w_sprod;
      MD_MULTU: {o_phi, o_plo} = w_uprod;
      MD_DIV: begin
        o_phi  = w_sr;
        o_plo  = w_sq;
        o_div0 = (i_rt == 32'd0);
      end
      MD_DIVU: begin
        o_phi  = w_ur;
        o_plo  = w_uq;
        o_div0 = (i_rt == 32'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_sched.sv
// HI/LO sequencer: accepts one E-stage op, models mult/div latency, commits
// HI/LO on completion and stalls D-stage HI/LO users meanwhile.
module md_sched
  import md_sched_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,  // >= 1
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,   // >= 1
  parameter int CNT_W       = CNT_W_DEF         // holds max latency
) (
  input  logic       clk,
  input  logic       reset,   // async, active low
  md_sched_if.slave  bus
);

  md_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_phi, r_plo, r_hi, r_lo;
  logic             r_div0;

  logic        w_take, w_start, w_done, w_busy;
  logic [31:0] w_phi, w_plo;
  logic        w_div0;

  md_arith u_arith (
    .i_op   (bus.op_E),
    .i_rs   (bus.rs_E),
    .i_rt   (bus.rt_E),
    .o_phi  (w_phi),
    .o_plo  (w_plo),
    .o_div0 (w_div0)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state, acceptance and completion decode.
  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_start     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Flush squashes the E-stage op before it can touch the resource.
        w_take  = !bus.flush;
        w_start = w_take && is_muldiv(bus.op_E);
        if (w_start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        // Ops arriving here are ignored; flush cannot cancel an older op.
        w_done = (r_cnt == CNT_W'(1));
        if (w_done) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Latency counter and pending result capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_phi  <= '0;
      r_plo  <= '0;
      r_div0 <= 1'b0;
    end else if (w_start) begin
      r_cnt  <= ((bus.op_E == MD_DIV) || (bus.op_E == MD_DIVU)) ?
                CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      r_phi  <= w_phi;
      r_plo  <= w_plo;
      r_div0 <= w_div0;
    end else if (r_state == S_RUN) begin
      r_cnt  <= r_cnt - CNT_W'(1);
    end
  end

  // Architectural HI/LO: commit on completion (unless div by zero) or mthi/mtlo.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_done) begin
      if (!r_div0) begin
        r_hi <= r_phi;
        r_lo <= r_plo;
      end
    end else if (w_take) begin
      if (bus.op_E == MD_MTHI) r_hi <= bus.rs_E;
      if (bus.op_E == MD_MTLO) r_lo <= bus.rs_E;
    end
  end

  assign w_busy       = (r_state == S_RUN);
  assign bus.start    = w_start;
  assign bus.busy     = w_busy;
  assign bus.stall_md = bus.md_D && (w_start || w_busy);
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;

endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched: latency, results, stall, flush and reset cases.
module tb_md_sched;
  import md_sched_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   errs = 0;
  int   checks = 0;

  md_sched_if bus ();

  md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one op for one cycle starting now (negedge+1); capture start/stall.
  task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic fl, output logic st, output logic stl);
    bus.op_E = op; bus.rs_E = rs; bus.rt_E = rt; bus.flush = fl;
    #1;
    st = bus.start; stl = bus.stall_md;
    @(negedge clk);
    bus.op_E = MD_NONE; bus.flush = 1'b0;
    #1;
  endtask

  // Count busy cycles (and stall cycles among them) until idle, bounded.
  task automatic wait_done(output int nb, output int ns);
    nb = 0; ns = 0;
    while (bus.busy === 1'b1 && nb < 40) begin
      nb++;
      if (bus.stall_md === 1'b1) ns++;
      @(negedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.op_E = MD_NONE; bus.rs_E = '0; bus.rt_E = '0; bus.flush = 1'b0; bus.md_D = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.hi !== 32'd0) begin errs++; $display("FAIL reset_hi: got %h want 0", bus.hi); end
    checks++; if (bus.lo !== 32'd0) begin errs++; $display("FAIL reset_lo: got %h want 0", bus.lo); end
    @(negedge clk); reset = 1'b1; #1;
    checks++; if (bus.start !== 1'b0) begin errs++; $display("FAIL reset_start: got %b want 0", bus.start); end
  endtask

  task automatic test_mult();
    logic st, stl; int nb, ns;
    issue(MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, st, stl);
    checks++; if (st !== 1'b1) begin errs++; $display("FAIL mult_start: got %b want 1", st); end
    checks++; if (bus.start !== 1'b0) begin errs++; $display("FAIL mult_start_pulse: got %b want 0", bus.start); end
    wait_done(nb, ns);
    checks++; if (nb != 5) begin errs++; $display("FAIL mult_busy_cycles: got %0d want 5", nb); end
    checks++; if (bus.hi !== 32'hFFFF_FFFF) begin errs++; $display("FAIL mult_hi: got %h want ffffffff", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFF_FFFA) begin errs++; $display("FAIL mult_lo: got %h want fffffffa", bus.lo); end
  endtask

  task automatic test_divu_stall();
    logic st, stl; int nb, ns;
    bus.md_D = 1'b1;
    issue(MD_DIVU, 32'd100, 32'd7, 1'b0, st, stl);
    checks++; if (stl !== 1'b1) begin errs++; $display("FAIL divu_stall_start: got %b want 1", stl); end
    wait_done(nb, ns);
    checks++; if (nb != 10) begin errs++; $display("FAIL divu_busy_cycles: got %0d want 10", nb); end
    checks++; if (ns != 10) begin errs++; $display("FAIL divu_stall_cycles: got %0d want 10", ns); end
    checks++; if (bus.lo !== 32'd14) begin errs++; $display("FAIL divu_lo: got %h want 0000000e", bus.lo); end
    checks++; if (bus.hi !== 32'd2) begin errs++; $display("FAIL divu_hi: got %h want 00000002", bus.hi); end
    checks++; if (bus.stall_md !== 1'b0) begin errs++; $display("FAIL divu_stall_end: got %b want 0", bus.stall_md); end
    bus.md_D = 1'b0;
  endtask

  task automatic test_div_signed();
    logic st, stl; int nb, ns;
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, st, stl);   // -7 / 2
    wait_done(nb, ns);
    checks++; if (bus.lo !== 32'hFFFF_FFFD) begin errs++; $display("FAIL div_neg_lo: got %h want fffffffd", bus.lo); end
    checks++; if (bus.hi !== 32'hFFFF_FFFF) begin errs++; $display("FAIL div_neg_hi: got %h want ffffffff", bus.hi); end
    issue(MD_DIV, 32'd5, 32'd0, 1'b0, st, stl);
    checks++; if (st !== 1'b1) begin errs++; $display("FAIL div0_start: got %b want 1", st); end
    wait_done(nb, ns);
    checks++; if (nb != 10) begin errs++; $display("FAIL div0_busy_cycles: got %0d want 10", nb); end
    checks++; if (bus.hi !== 32'hFFFF_FFFF) begin errs++; $display("FAIL div0_hi: got %h want ffffffff", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFF_FFFD) begin errs++; $display("FAIL div0_lo: got %h want fffffffd", bus.lo); end
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, st, stl);
    wait_done(nb, ns);
    checks++; if (bus.lo !== 32'h8000_0000) begin errs++; $display("FAIL div_ovf_lo: got %h want 80000000", bus.lo); end
    checks++; if (bus.hi !== 32'd0) begin errs++; $display("FAIL div_ovf_hi: got %h want 00000000", bus.hi); end
  endtask

  task automatic test_flush();
    logic st, stl; int nb, ns;
    issue(MD_MULT, 32'd7, 32'd6, 1'b1, st, stl);
    checks++; if (st !== 1'b0) begin errs++; $display("FAIL flush_start: got %b want 0", st); end
    checks++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL flush_busy: got %b want 0", bus.busy); end
    checks++; if (bus.lo !== 32'h8000_0000) begin errs++; $display("FAIL flush_lo: got %h want 80000000", bus.lo); end
    issue(MD_MULT, 32'd7, 32'd6, 1'b0, st, stl);
    nb = 0;
    while (bus.busy === 1'b1 && nb < 40) begin
      nb++;
      bus.flush = (nb == 2);
      @(negedge clk); #1;
    end
    bus.flush = 1'b0;
    checks++; if (nb != 5) begin errs++; $display("FAIL flush_run_cycles: got %0d want 5", nb); end
    checks++; if (bus.lo !== 32'd42) begin errs++; $display("FAIL flush_run_lo: got %h want 0000002a", bus.lo); end
    checks++; if (bus.hi !== 32'd0) begin errs++; $display("FAIL flush_run_hi: got %h want 00000000", bus.hi); end
  endtask

  task automatic test_mthi_mtlo();
    logic st, stl; int nb;
    issue(MD_MTHI, 32'h0000_1234, 32'd0, 1'b0, st, stl);
    checks++; if (st !== 1'b0) begin errs++; $display("FAIL mthi_start: got %b want 0", st); end
    checks++; if (bus.hi !== 32'h0000_1234) begin errs++; $display("FAIL mthi_hi: got %h want 00001234", bus.hi); end
    checks++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL mthi_busy: got %b want 0", bus.busy); end
    checks++; if (bus.lo !== 32'd42) begin errs++; $display("FAIL mthi_lo_kept: got %h want 0000002a", bus.lo); end
    issue(MD_MULT, 32'd3, 32'd4, 1'b0, st, stl);
    nb = 0;
    while (bus.busy === 1'b1 && nb < 40) begin
      nb++;
      bus.op_E = (nb == 2) ? MD_MTLO : MD_NONE;
      bus.rs_E = 32'hDEAD_BEEF;
      @(negedge clk); #1;
    end
    bus.op_E = MD_NONE;
    checks++; if (nb != 5) begin errs++; $display("FAIL mtlo_busy_cycles: got %0d want 5", nb); end
    checks++; if (bus.lo !== 32'd12) begin errs++; $display("FAIL mtlo_ignored_lo: got %h want 0000000c", bus.lo); end
    checks++; if (bus.hi !== 32'd0) begin errs++; $display("FAIL mtlo_ignored_hi: got %h want 00000000", bus.hi); end
  endtask

  task automatic test_reset_mid_run();
    logic st, stl; int nb, ns;
    issue(MD_MTHI, 32'h0000_0055, 32'd0, 1'b0, st, stl);
    issue(MD_DIV, 32'd100, 32'd3, 1'b0, st, stl);   // now in busy cycle 1
    repeat (2) begin @(negedge clk); #1; end          // busy cycle 3
    checks++; if (bus.busy !== 1'b1) begin errs++; $display("FAIL rst_run_busy_before: got %b want 1", bus.busy); end
    reset = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL rst_run_busy: got %b want 0", bus.busy); end
    checks++; if (bus.hi !== 32'd0) begin errs++; $display("FAIL rst_run_hi: got %h want 00000000", bus.hi); end
    checks++; if (bus.lo !== 32'd0) begin errs++; $display("FAIL rst_run_lo: got %h want 00000000", bus.lo); end
    @(negedge clk); reset = 1'b1; #1;
    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, st, stl);
    checks++; if (st !== 1'b1) begin errs++; $display("FAIL post_rst_start: got %b want 1", st); end
    wait_done(nb, ns);
    checks++; if (nb != 5) begin errs++; $display("FAIL post_rst_busy_cycles: got %0d want 5", nb); end
    checks++; if (bus.hi !== 32'hFFFF_FFFE) begin errs++; $display("FAIL multu_hi: got %h want fffffffe", bus.hi); end
    checks++; if (bus.lo !== 32'h0000_0001) begin errs++; $display("FAIL multu_lo: got %h want 00000001", bus.lo); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_divu_stall();
    test_div_signed();
    test_flush();
    test_mthi_mtlo();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
